// File: rtl/register_file_32x32_sb_pkg.sv
// Shared constants for the 32x32 register file with pending scoreboard.
// Holds data/address widths, the stack-pointer defaults and the register-0 index.
package register_file_32x32_sb_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 1 << ADDR_WIDTH;
    localparam int REG_ZERO   = 0;

    localparam int                    SP_INDEX_DEFAULT = 29;
    localparam logic [DATA_WIDTH-1:0] SP_INIT_DEFAULT  = 32'h03FF_FFFF;

    // True when both addresses name the same architecturally writable register.
    function automatic logic nz_match(input logic [ADDR_WIDTH-1:0] a,
                                      input logic [ADDR_WIDTH-1:0] b);
        return (a == b) && (a != ADDR_WIDTH'(REG_ZERO));
    endfunction

endpackage

// File: rtl/MUX32_32x1.sv
// 32-input, one-output word multiplexer; inputs packed word 0 in the low bits.
// Every select code picks a defined word, so no X leaks out of the read path.
module MUX32_32x1 #(
    parameter int WIDTH = 32
) (
    input  logic [32*WIDTH-1:0] data,
    input  logic [4:0]          sel,
    output logic [WIDTH-1:0]    y
);

    assign y = data[sel*WIDTH +: WIDTH];

endmodule

// File: rtl/register_cell_32.sv
// One architectural register: flop with load enable and synchronous
// active-high reset to a per-instance value.
module register_cell_32 #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state uses non-blocking assignment so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file_32x32_sb.sv
// 32x32 register file with registered dual read ports, one write port and a
// per-register pending scoreboard used by issue logic to detect in-flight writes.
module register_file_32x32_sb
    import register_file_32x32_sb_pkg::*;
#(
    parameter int               WIDTH      = DATA_WIDTH,
    parameter int               DEPTH_LOG2 = ADDR_WIDTH,
    parameter int               SP_INDEX   = SP_INDEX_DEFAULT,
    parameter logic [WIDTH-1:0] SP_INIT    = SP_INIT_DEFAULT,
    parameter int               BYPASS     = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic [DEPTH_LOG2-1:0] ADDR_R1,
    input  logic [DEPTH_LOG2-1:0] ADDR_R2,
    output logic [WIDTH-1:0]      DATA_R1,
    output logic [WIDTH-1:0]      DATA_R2,
    output logic                  BUSY_R1,
    output logic                  BUSY_R2,
    input  logic                  WRITE,
    input  logic [DEPTH_LOG2-1:0] ADDR_W,
    input  logic [WIDTH-1:0]      DATA_W,
    input  logic                  RESERVE,
    input  logic [DEPTH_LOG2-1:0] ADDR_RSV
);

    localparam int   REGS      = 1 << DEPTH_LOG2;
    localparam logic BYPASS_EN = (BYPASS != 0);

    logic [REGS-1:1]      wr_en;
    logic [REGS-1:1]      rsv_en;
    logic [REGS-1:1]      pending_q;
    logic [REGS-1:0]      pending;
    wire  [REGS*WIDTH-1:0] reg_flat;
    logic [WIDTH-1:0]     mux_r1;
    logic [WIDTH-1:0]     mux_r2;
    logic                 fwd_r1;
    logic                 fwd_r2;

    // 5x32 address decoders; entry 0 has no storage, so its decode is dropped.
    for (genvar i = 1; i < REGS; i++) begin : g_decode
        assign wr_en[i]  = WRITE   && (ADDR_W   == DEPTH_LOG2'(i));
        assign rsv_en[i] = RESERVE && (ADDR_RSV == DEPTH_LOG2'(i));
    end

    // NOTE: every register carries its own reset; the stack pointer and the
    // zero registers are architecturally defined from the first cycle.
    assign reg_flat[WIDTH-1:0] = '0;
    for (genvar i = 1; i < REGS; i++) begin : g_reg
        localparam logic [WIDTH-1:0] RV = (i == SP_INDEX) ? SP_INIT : '0;
        register_cell_32 #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RV)
        ) u_cell (
            .clk  (CLK),
            .rst  (RST),
            .load (wr_en[i]),
            .d    (DATA_W),
            .q    (reg_flat[i*WIDTH +: WIDTH])
        );
    end

    // Scoreboard: a write retires the producer, a same-cycle reserve re-arms it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~wr_en) | rsv_en;
        end
    end

    assign pending = {pending_q, 1'b0};

    MUX32_32x1 #(.WIDTH(WIDTH)) u_mux_r1 (
        .data (reg_flat),
        .sel  (ADDR_R1),
        .y    (mux_r1)
    );

    MUX32_32x1 #(.WIDTH(WIDTH)) u_mux_r2 (
        .data (reg_flat),
        .sel  (ADDR_R2),
        .y    (mux_r2)
    );

    assign fwd_r1 = BYPASS_EN && WRITE && nz_match(ADDR_W, ADDR_R1);
    assign fwd_r2 = BYPASS_EN && WRITE && nz_match(ADDR_W, ADDR_R2);

    // A forwarded write satisfies the operand now, so busy drops in that cycle.
    assign BUSY_R1 = pending[ADDR_R1] && !fwd_r1;
    assign BUSY_R2 = pending[ADDR_R2] && !fwd_r2;

    always_ff @(posedge CLK) begin
        if (RST) begin
            DATA_R1 <= '0;
            DATA_R2 <= '0;
        end else if (READ) begin
            DATA_R1 <= fwd_r1 ? DATA_W : mux_r1;
            DATA_R2 <= fwd_r2 ? DATA_W : mux_r2;
        end
    end

endmodule

// File: tb/tb_register_file_32x32_sb.sv
// Randomised bench for register_file_32x32_sb: a forwarding and a read-old
// instance share stimulus and are compared against an array-based model.
module tb_register_file_32x32_sb;

    logic        CLK;
    logic        RST;
    logic        READ;
    logic [4:0]  ADDR_R1;
    logic [4:0]  ADDR_R2;
    logic        WRITE;
    logic [4:0]  ADDR_W;
    logic [31:0] DATA_W;
    logic        RESERVE;
    logic [4:0]  ADDR_RSV;

    logic [31:0] data_r1_b, data_r2_b, data_r1_o, data_r2_o;
    logic        busy_r1_b, busy_r2_b, busy_r1_o, busy_r2_o;

    register_file_32x32_sb #(.BYPASS(1)) dut_byp (
        .CLK(CLK), .RST(RST), .READ(READ),
        .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
        .DATA_R1(data_r1_b), .DATA_R2(data_r2_b),
        .BUSY_R1(busy_r1_b), .BUSY_R2(busy_r2_b),
        .WRITE(WRITE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .RESERVE(RESERVE), .ADDR_RSV(ADDR_RSV)
    );

    register_file_32x32_sb #(.BYPASS(0)) dut_old (
        .CLK(CLK), .RST(RST), .READ(READ),
        .ADDR_R1(ADDR_R1), .ADDR_R2(ADDR_R2),
        .DATA_R1(data_r1_o), .DATA_R2(data_r2_o),
        .BUSY_R1(busy_r1_o), .BUSY_R2(busy_r2_o),
        .WRITE(WRITE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .RESERVE(RESERVE), .ADDR_RSV(ADDR_RSV)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: architectural contents, pending flags, expected outputs.
    logic [31:0] mem [32];
    bit          pend [32];
    logic [31:0] e1b, e2b, e1o, e2o;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        return pend[a] && !(byp && WRITE && ADDR_W == a && a != 5'd0);
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
        if (byp && WRITE && ADDR_W == a && a != 5'd0) return DATA_W;
        return mem[a];
    endfunction

    task automatic model_edge();
        if (RST) begin
            for (int i = 0; i < 32; i++) begin
                mem[i]  = (i == 29) ? 32'h03FF_FFFF : 32'h0;
                pend[i] = 1'b0;
            end
            e1b = '0; e2b = '0; e1o = '0; e2o = '0;
        end else begin
            if (READ) begin
                e1b = exp_read(ADDR_R1, 1'b1);
                e2b = exp_read(ADDR_R2, 1'b1);
                e1o = exp_read(ADDR_R1, 1'b0);
                e2o = exp_read(ADDR_R2, 1'b0);
            end
            if (WRITE && ADDR_W != 5'd0) begin
                mem[ADDR_W]  = DATA_W;
                pend[ADDR_W] = 1'b0;
            end
            if (RESERVE && ADDR_RSV != 5'd0) pend[ADDR_RSV] = 1'b1;
        end
    endtask

    // One clock: drive, check busy mid-cycle, clock the model, check read data.
    task automatic step(input logic rst, input logic rd,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic wr, input logic [4:0] aw, input logic [31:0] dw,
                        input logic rsv, input logic [4:0] ar);
        RST = rst; READ = rd; ADDR_R1 = a1; ADDR_R2 = a2;
        WRITE = wr; ADDR_W = aw; DATA_W = dw; RESERVE = rsv; ADDR_RSV = ar;
        @(negedge CLK);
        check("busy_r1_byp", {31'b0, busy_r1_b}, {31'b0, exp_busy(a1, 1'b1)});
        check("busy_r2_byp", {31'b0, busy_r2_b}, {31'b0, exp_busy(a2, 1'b1)});
        check("busy_r1_old", {31'b0, busy_r1_o}, {31'b0, exp_busy(a1, 1'b0)});
        check("busy_r2_old", {31'b0, busy_r2_o}, {31'b0, exp_busy(a2, 1'b0)});
        @(posedge CLK);
        model_edge();
        #1;
        check("data_r1_byp", data_r1_b, e1b);
        check("data_r2_byp", data_r2_b, e2b);
        check("data_r1_old", data_r1_o, e1o);
        check("data_r2_old", data_r2_o, e2o);
    endtask

    function automatic logic [4:0] rand_addr();
        // Bias toward a few registers so collisions and forwarding happen often.
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 5));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        RST = 1'b1; READ = 1'b0; ADDR_R1 = '0; ADDR_R2 = '0;
        WRITE = 1'b0; ADDR_W = '0; DATA_W = '0; RESERVE = 1'b0; ADDR_RSV = '0;
        @(posedge CLK);
        model_edge();
        #1;

        // Reset pulse, then read SP and an ordinary register.
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 29, 5, 0, 0, 0, 0, 0);
        check("sp_reset_value", data_r1_b, 32'h03FF_FFFF);

        // Write then read, then hold with READ low.
        step(0, 0, 0, 0, 1, 7, 32'hDEAD_BEEF, 0, 0);
        step(0, 1, 7, 0, 0, 0, 0, 0, 0);
        check("r7_readback", data_r1_b, 32'hDEAD_BEEF);
        step(0, 0, 3, 3, 0, 0, 0, 0, 0);
        step(0, 0, 3, 3, 1, 7, 32'h1111_2222, 0, 0);

        // Register 0: write and reserve are both ignored.
        step(0, 1, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);

        // Forwarding versus read-old on a same-cycle write.
        step(0, 0, 0, 0, 1, 3, 32'h1, 0, 0);
        step(0, 1, 3, 3, 1, 3, 32'h1234_5678, 0, 0);
        check("fwd_byp", data_r1_b, 32'h1234_5678);
        check("fwd_old", data_r2_o, 32'h1);

        // Scoreboard: reserve, write-clear, reserve+write collision.
        step(0, 0, 9, 9, 0, 0, 0, 1, 9);
        step(0, 0, 9, 9, 0, 0, 0, 0, 0);
        step(0, 1, 9, 0, 1, 9, 32'hCAFE_0009, 0, 0);
        step(0, 0, 9, 9, 0, 0, 0, 0, 0);
        step(0, 0, 9, 9, 1, 9, 32'h0000_0099, 1, 9);
        step(0, 1, 9, 9, 0, 0, 0, 0, 0);

        // Reset mid-operation drops reservations and data.
        step(0, 0, 4, 6, 0, 0, 0, 1, 4);
        step(0, 0, 4, 6, 0, 0, 0, 1, 6);
        step(0, 0, 4, 6, 1, 4, 32'h55, 0, 0);
        step(1, 0, 4, 6, 0, 0, 0, 1, 4);
        step(0, 1, 4, 6, 0, 0, 0, 0, 0);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 1)),
                 rand_addr(), rand_addr(),
                 1'($urandom_range(0, 1)), rand_addr(), $urandom(),
                 1'($urandom_range(0, 2) == 0), rand_addr());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/register_file_32x32_sb.md
Name: register_file_32x32_sb

Overview:
- 32-entry x 32-bit register file with a per-register pending scoreboard.
- Sits directly upstream of the 32-bit 32x1 read-select mux.
  - Each read port's 32 register values feed one MUX32_32x1 instance.
  - The registered mux result is presented to the ALU operand stage.
- The scoreboard lets issue logic see whether an operand still awaits an in-flight write.

Parameters:
- WIDTH, 32: data word width.
- DEPTH_LOG2, 5: address width; 32 registers.
- SP_INDEX, 29: index of the stack-pointer register.
- SP_INIT, 32'h03FF_FFFF: reset value of the stack-pointer register.
- BYPASS, 1: 1 means write-first forwarding on same-cycle read/write to the same address; 0 means read-old.

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST  input  1  reset, synchronous, active-high.
- READ  input  1  capture enable for both read ports.
- ADDR_R1  input  5  read port 1 address.
- ADDR_R2  input  5  read port 2 address.
- DATA_R1  output  32  registered read data, port 1.
- DATA_R2  output  32  registered read data, port 2.
- BUSY_R1  output  1  combinational: operand at ADDR_R1 is pending.
- BUSY_R2  output  1  combinational: operand at ADDR_R2 is pending.
- WRITE  input  1  write enable.
- ADDR_W  input  5  write address.
- DATA_W  input  32  write data.
- RESERVE  input  1  mark ADDR_RSV as pending; a new producer has been issued.
- ADDR_RSV  input  5  register to reserve.

Behaviour:
- Interface (already decided): one clock, CLK; reset RST is synchronous and active-high. All state updates occur on the rising edge of CLK only.
- Reset (RST=1 at an edge):
  - All registers become 0, except reg[SP_INDEX], which becomes SP_INIT.
  - All pending bits become 0.
  - DATA_R1 and DATA_R2 become 0.
  - RST overrides READ, WRITE and RESERVE in the same cycle.
  - Reset asserted mid-sequence discards all outstanding reservations.
- Register 0:
  - Always reads 0.
  - Writes to it are ignored.
  - Reserving it is ignored; pending[0] is constant 0.
- Write: at an edge with WRITE=1 and ADDR_W != 0, reg[ADDR_W] <= DATA_W and pending[ADDR_W] <= 0.
- Read:
  - At an edge with READ=1, DATA_Rn <= reg[ADDR_Rn], selected through MUX32_32x1. Latency is 1 cycle.
  - With READ=0, DATA_Rn holds its value.
- Same-cycle read and write, same nonzero address:
  - BYPASS=1: DATA_Rn <= DATA_W.
  - BYPASS=0: DATA_Rn <= old value.
  - Both ports forward independently.
- Reserve: at an edge with RESERVE=1 and ADDR_RSV != 0, pending[ADDR_RSV] <= 1.
- Reserve and write in the same cycle:
  - Same address: the pending bit ends at 1 (reserve wins), and the data is still written.
  - Different addresses: both take effect.
- BUSY_Rn = pending[ADDR_Rn] & ~(BYPASS & WRITE & ADDR_W==ADDR_Rn & ADDR_W!=0).
  - A write arriving in the same cycle clears busy combinationally only when BYPASS=1.
- Reserving an already pending register keeps it at 1; there is no count.
- A write to a non-pending register is legal and leaves pending at 0.
- No X propagation: all addresses are fully decoded.

Decomposition:
- Shared definitions include (prj_definition):
  - data-width and address-width constants;
  - SP_INDEX and SP_INIT defaults;
  - register-0 index constant.
- Sub-module register_cell_32:
  - 32-bit flop with synchronous active-high reset to a parameterised value, plus load enable.
  - Instantiated 31 times; register 0 is a constant.
- The read path reuses MUX32_32x1, two instances.
- The write enable decodes through a 5x32 decoder.

Test Plan:
- Reset: pulse RST 1 cycle, then READ ADDR_R1=29, ADDR_R2=5 -> DATA_R1=32'h03FFFFFF, DATA_R2=0; BUSY_R1=BUSY_R2=0.
- Write then read: WRITE ADDR_W=7 DATA_W=32'hDEADBEEF; next cycle READ ADDR_R1=7 -> DATA_R1=32'hDEADBEEF one edge later; with READ=0 afterwards, DATA_R1 holds.
- Register 0: WRITE ADDR_W=0 DATA_W=32'hFFFFFFFF and RESERVE ADDR_RSV=0; READ ADDR_R2=0 -> DATA_R2=0, BUSY_R2=0.
- Bypass: with BYPASS=1, reg3=1; same cycle WRITE ADDR_W=3 DATA_W=32'h12345678 and READ ADDR_R1=ADDR_R2=3 -> both ports show 32'h12345678. With BYPASS=0 the same stimulus gives 1.
- Scoreboard:
  - RESERVE ADDR_RSV=9 -> BUSY_R1=1 for ADDR_R1=9 from the next cycle.
  - WRITE ADDR_W=9 -> BUSY_R1 drops combinationally in the write cycle when BYPASS=1, and pending is cleared after the edge.
  - RESERVE and WRITE both to 9 in one cycle -> BUSY stays 1.
- Reset mid-operation: reserve regs 4 and 6, write reg4=0x55, assert RST -> pending all 0 and reg4=0 on the next read.
